sample_out_monitor: RTL and testbench

Downstream capture stage for the `sample` logic netlist. Samples its `o`, `p`, `q` outputs each enabled cycle and detects changes against the last sample. Each change is written as a timestamped event into a small FIFO, drained over a valid/ready stream. Also keeps saturating rising-edge counters per output and a sticky overflow flag for bring-up and regression observation.

---
 rtl/sample_mon_pkg.sv | 19 +
 rtl/sample_mon_fifo.sv | 47 ++++
 rtl/sample_out_monitor.sv | 103 ++++++++++
 tb/tb_sample_out_monitor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_mon_pkg.sv
// Shared types and helpers for the sample netlist output monitor.
package sample_mon_pkg;

  localparam int unsigned VEC_W   = 3;
  localparam int unsigned EV_TS_W = 16;

  typedef struct packed {
    logic [EV_TS_W-1:0] ts;
    logic [VEC_W-1:0]   vec;
  } ev_t;

  // Increment cnt, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (cnt >= max_val) ? max_val : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/sample_mon_fifo.sv
// Fall-through synchronous FIFO with registered storage and wrap-bit pointers.
module sample_mon_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sample_out_monitor.sv
// Captures o/p/q changes as timestamped events into a FIFO and keeps
// saturating per-output rise counters plus a sticky drop flag.
module sample_out_monitor
  import sample_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = EV_TS_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     o,
  input  logic                     p,
  input  logic                     q,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W+VEC_W-1:0]    ev_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf,
  input  logic                     clr_ovf,
  output logic [CNT_W-1:0]         o_rise_cnt,
  output logic [CNT_W-1:0]         p_rise_cnt,
  output logic [CNT_W-1:0]         q_rise_cnt
);

  localparam int unsigned EW = TS_W + VEC_W;

  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] last_vec;
  logic             primed;
  logic [TS_W-1:0]  ts_cnt;
  logic             ev_gen;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;
  logic [VEC_W-1:0] rise;
  logic [CNT_W-1:0] rise_cnt [VEC_W];

  assign vec      = {q, p, o};
  assign ev_gen   = en && (!primed || (vec != last_vec));
  assign ev_valid = !empty;
  assign pop      = ev_valid && ev_ready;
  assign drop     = ev_gen && full && !pop;
  assign rise     = {VEC_W{en && primed}} & ~last_vec & vec;

  sample_mon_fifo #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ev_gen),
    .wdata ({ts_cnt, vec}),
    .pop   (pop),
    .rdata (ev_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Free-running timestamp and change-detection history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt   <= '0;
      last_vec <= '0;
      primed   <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (en) begin
        last_vec <= vec;
        primed   <= 1'b1;
      end
    end
  end

  // Drop flag: a set in the same cycle wins over a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(VEC_W); i++) rise_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(VEC_W); i++) begin
        if (rise[i]) rise_cnt[i] <= CNT_W'(sat_inc(32'(rise_cnt[i]), CNT_W));
      end
    end
  end

  assign o_rise_cnt = rise_cnt[0];
  assign p_rise_cnt = rise_cnt[1];
  assign q_rise_cnt = rise_cnt[2];

endmodule

// File: tb/tb_sample_out_monitor.sv
// Directed bench for sample_out_monitor with hand-computed expectations.
module tb_sample_out_monitor;
  import sample_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        o;
  logic        p;
  logic        q;
  logic        ev_valid;
  logic        ev_ready;
  logic [18:0] ev_data;
  logic [2:0]  fifo_level;
  logic        ovf;
  logic        clr_ovf;
  logic [7:0]  o_rise_cnt;
  logic [7:0]  p_rise_cnt;
  logic [7:0]  q_rise_cnt;

  int          n_chk;
  int          n_fail;
  logic [15:0] ts_now;
  logic [15:0] exp_ts  [6];
  logic [2:0]  exp_vec [6];
  logic        saw_ev;

  sample_out_monitor #(
    .DEPTH (4),
    .TS_W  (16),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .o          (o),
    .p          (p),
    .q          (q),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_data    (ev_data),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf),
    .o_rise_cnt (o_rise_cnt),
    .p_rise_cnt (p_rise_cnt),
    .q_rise_cnt (q_rise_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ev(input logic [15:0] ts, input logic [2:0] v);
    ev_t e;
    e.ts  = ts;
    e.vec = v;
    return 32'(e);
  endfunction

  // One clock; the bench's timestamp mirror advances only out of reset.
  task automatic tick();
    @(posedge clk);
    if (rst) ts_now++;
    #1;
  endtask

  task automatic setv(input logic [2:0] v);
    {q, p, o} = v;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(ev_valid),   32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_ovf"},   32'(ovf),        32'd0);
    chk({tag, "_orc"},   32'(o_rise_cnt), 32'd0);
    chk({tag, "_prc"},   32'(p_rise_cnt), 32'd0);
    chk({tag, "_qrc"},   32'(q_rise_cnt), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; ts_now = '0; saw_ev = 1'b0;
    rst = 1'b0; en = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
    setv(3'b000);
    repeat (3) tick();
    chk_reset_outputs("reset");

    // First sample after release is always an event, stamped ts=0.
    rst = 1'b1; ts_now = '0; en = 1'b1; setv(3'b000);
    tick();
    chk("first_valid", 32'(ev_valid),   32'd1);
    chk("first_data",  32'(ev_data),    mk_ev(16'd0, 3'b000));
    chk("first_level", 32'(fifo_level), 32'd1);

    ev_ready = 1'b1; setv(3'b001);
    tick();
    chk("step1_data",  32'(ev_data),    mk_ev(16'd1, 3'b001));
    chk("step1_level", 32'(fifo_level), 32'd1);
    setv(3'b001);
    tick();
    chk("nochg_valid", 32'(ev_valid),   32'd0);
    chk("nochg_level", 32'(fifo_level), 32'd0);
    setv(3'b101);
    tick();
    chk("step3_data",  32'(ev_data),    mk_ev(16'd3, 3'b101));
    chk("step3_orc",   32'(o_rise_cnt), 32'd1);
    chk("step3_qrc",   32'(q_rise_cnt), 32'd1);
    chk("step3_prc",   32'(p_rise_cnt), 32'd0);
    en = 1'b0;
    tick();
    chk("drain_level", 32'(fifo_level), 32'd0);

    // Six changes into a 4-deep FIFO with no consumer: two are dropped.
    ev_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_vec[i] = (i % 2 == 0) ? 3'b100 : 3'b101;
      exp_ts[i]  = ts_now;
      setv(exp_vec[i]);
      tick();
    end
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_set",   32'(ovf),        32'd1);
    en = 1'b0; ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_valid%0d", i), 32'(ev_valid), 32'd1);
      chk($sformatf("ovf_data%0d", i),  32'(ev_data),  mk_ev(exp_ts[i], exp_vec[i]));
      tick();
    end
    chk("ovf_empty",  32'(fifo_level), 32'd0);
    chk("ovf_sticky", 32'(ovf),        32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Full FIFO with a simultaneous pop accepts the new event.
    ev_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      setv((i % 2 == 0) ? 3'b100 : 3'b101);
      tick();
    end
    chk("full_level", 32'(fifo_level), 32'd4);
    ev_ready = 1'b1; setv(3'b100);
    tick();
    chk("fullpop_level", 32'(fifo_level), 32'd4);
    chk("fullpop_ovf",   32'(ovf),        32'd0);
    en = 1'b0;
    repeat (4) tick();
    chk("fullpop_drain", 32'(fifo_level), 32'd0);

    // Rise counter saturation on p.
    en = 1'b1; ev_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      setv(3'b110); tick();
      setv(3'b100); tick();
    end
    chk("prc_100", 32'(p_rise_cnt), 32'd100);
    for (int k = 0; k < 200; k++) begin
      setv(3'b110); tick();
      setv(3'b100); tick();
    end
    chk("prc_sat", 32'(p_rise_cnt), 32'd255);
    chk("orc_tot", 32'(o_rise_cnt), 32'd6);
    chk("qrc_tot", 32'(q_rise_cnt), 32'd1);
    chk("sat_ovf", 32'(ovf),        32'd0);

    // Build up state (including ovf) then reset mid-stream.
    ev_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      setv((k % 2 == 0) ? 3'b110 : 3'b100);
      tick();
    end
    chk("pre_rst_ovf",   32'(ovf),        32'd1);
    chk("pre_rst_level", 32'(fifo_level), 32'd4);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst = 1'b1; ts_now = '0;
    tick();
    chk("rel_valid", 32'(ev_valid), 32'd1);
    chk("rel_data",  32'(ev_data),  mk_ev(16'd0, 3'b110));

    // en=0 across a full timestamp wrap: inputs move, nothing is captured.
    en = 1'b0; ev_ready = 1'b1;
    tick();
    chk("wrap_pre_level", 32'(fifo_level), 32'd0);
    begin
      int n;
      n = 65536 - int'(ts_now);
      for (int i = 0; i < n; i++) begin
        setv(3'(i));
        tick();
        if (ev_valid) saw_ev = 1'b1;
      end
    end
    chk("en0_no_event", 32'(saw_ev),     32'd0);
    chk("en0_orc",      32'(o_rise_cnt), 32'd0);
    chk("en0_prc",      32'(p_rise_cnt), 32'd0);
    en = 1'b1; setv(3'b001);
    tick();
    chk("wrap_valid", 32'(ev_valid),   32'd1);
    chk("wrap_data",  32'(ev_data),    mk_ev(16'd0, 3'b001));
    chk("wrap_orc",   32'(o_rise_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
